sync_fifo_param: RTL
====================

Name: sync_fifo_param

Overview:
Parametrised synchronous single-clock FIFO. It is the next generation of the team's datapath FIFO, used between producer stages (DTP) and consumer muxes.
- Generalised width, depth and threshold flags.
- Exact occupancy count.
- Well-defined simultaneous push/pop at full and empty.
- Sticky overflow/underflow error reporting.
- Optional first-word-fall-through read mode.

Parameters:
DATA_W, 16, data word width in bits (>=1)
DEPTH, 8, number of entries; power of two, >=2
AF_LEVEL, 6, o_almost_full asserts when count >= AF_LEVEL (1..DEPTH)
AE_LEVEL, 2, o_almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1)
Derived (localparam, not overridable): ADDR_W = $clog2(DEPTH); CNT_W = ADDR_W+1

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
i_push  in  1  write request
i_data  in  DATA_W  write data, sampled on accepted push
i_pop  in  1  read request
o_data  out  DATA_W  read data
o_valid  out  1  o_data holds a valid popped word (see Behaviour)
o_count  out  CNT_W  current occupancy, 0..DEPTH
o_full  out  1  count == DEPTH
o_empty  out  1  count == 0
o_almost_full  out  1  count >= AF_LEVEL
o_almost_empty  out  1  count <= AE_LEVEL
o_overflow  out  1  sticky: push was rejected
o_underflow  out  1  sticky: pop was rejected
i_clr_err  in  1  clears both sticky error flags

Behaviour:
Reset: rst_n is synchronous and active-low; clk is the clock. On a clk edge with rst_n=0:
- wr_ptr, rd_ptr and count go to 0.
- o_data=0, o_valid=0, o_overflow=0, o_underflow=0.
- Storage array is not reset.
- Reset mid-operation discards all contents; the first push after reset lands at entry 0.

Pointers and count:
- ADDR_W-bit pointers wrap naturally from DEPTH-1 to 0.
- count is a registered CNT_W-bit value. Full and empty are decided from count, never from pointer compare.

Acceptance (all evaluated on current-cycle registered state):
- pop_ok = i_pop & !o_empty.
- push_ok = i_push & (!o_full | pop_ok). A push while full is accepted only when a pop is accepted in the same cycle.
- Pop while empty is rejected even if push is asserted. There is no bypass; the pushed word is stored normally.
- count_next = count + push_ok - pop_ok.
- Status outputs are combinational from registered count, so they update the cycle after the accepting edge.

Read timing (default, registered):
- On pop_ok, o_data <= mem[rd_ptr] and o_valid <= 1 for exactly the next cycle. Latency is 1 clock.
- Otherwise o_valid <= 0 and o_data holds its last value.

Write: on push_ok, mem[wr_ptr] <= i_data and wr_ptr increments.

Errors:
- o_overflow sets on i_push & !push_ok.
- o_underflow sets on i_pop & !pop_ok.
- Both hold until i_clr_err=1 or reset.
- If clear and a new error occur in the same cycle, set wins.

Thresholds: combinational compares on count. AF_LEVEL=DEPTH makes o_almost_full identical to o_full.

Optional Feature:
Macro SYNC_FIFO_FWFT_EN.
- Defined: first-word-fall-through mode.
  - o_data = mem[rd_ptr] combinationally.
  - o_valid = !o_empty.
  - pop_ok consumes the displayed word in the same cycle. The read register is removed and read latency is 0.
  - After reset, o_data is don't-care while o_valid=0.
- Undefined: registered read as described above.
- Acceptance, count, flags and errors are identical in both modes.

Test Plan:
1. Reset, then push 0x0001..0x0008 on 8 consecutive cycles -> o_count=8, o_full=1, o_almost_full=1 from count 6; o_overflow stays 0.
2. From full, pop 8 times -> o_valid pulses 1 cycle after each pop with 0x0001..0x0008 in order (FWFT: same cycle); then o_empty=1 and o_almost_empty=1 from count 2.
3. Full, then push 0xAAAA and pop in the same cycle -> count stays 8; oldest word out; 0xAAAA is read last; no overflow.
4. Empty, then push 0x5555 and pop in the same cycle -> pop rejected, o_underflow=1, count=1; next pop returns 0x5555.
5. Push on full with no pop -> o_overflow=1 and data not written. Assert i_clr_err -> 0 next cycle. Clear plus overflow in the same cycle -> stays 1.
6. Wrap and reset: push 5, pop 5, push 6 (pointers wrap); assert rst_n=0 for one cycle with count=6 -> count=0, o_empty=1, o_valid=0; next push and pop returns the new word.

Source files
------------

// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - parametrised single-clock FIFO with exact count, thresholds and sticky errors
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is a 1-cycle registered read.
module sync_fifo_param #(
  parameter int DATA_W   = 16,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = 6,
  parameter int AE_LEVEL = 2,
  localparam int ADDR_W  = $clog2(DEPTH),
  localparam int CNT_W   = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  output logic [CNT_W-1:0]  o_count,
  output logic              o_full,
  output logic              o_empty,
  output logic              o_almost_full,
  output logic              o_almost_empty,
  output logic              o_overflow,
  output logic              o_underflow,
  input  logic              i_clr_err
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              full, empty, push_ok, pop_ok;

  // Full/empty come from the registered count only, never from pointer compare.
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

  always_comb begin
    pop_ok      = i_pop & ~empty;
    push_ok     = i_push & (~full | pop_ok);
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    mem_d       = mem_q;
    overflow_d  = (overflow_q & ~i_clr_err) | (i_push & ~push_ok);
    underflow_d = (underflow_q & ~i_clr_err) | (i_pop & ~pop_ok);
    if (push_ok) begin
      mem_d[wr_ptr_q] = i_data;
      wr_ptr_d        = wr_ptr_q + ADDR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign o_data  = mem_q[rd_ptr_q];
  assign o_valid = ~empty;
`else
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;

  always_comb begin
    data_d  = data_q;
    valid_d = pop_ok;
    if (pop_ok) begin
      data_d = mem_q[rd_ptr_q];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign o_data  = data_q;
  assign o_valid = valid_q;
`endif

  assign o_count        = count_q;
  assign o_full         = full;
  assign o_empty        = empty;
  assign o_almost_full  = (count_q >= CNT_W'(AF_LEVEL));
  assign o_almost_empty = (count_q <= CNT_W'(AE_LEVEL));
  assign o_overflow     = overflow_q;
  assign o_underflow    = underflow_q;

endmodule
